// File: rtl/alu_md_pkg.sv
// alu_md_seq shared definitions
// opcodes, FSM states, opcode class helper
package alu_md_pkg;

   localparam logic [5:0] OP_SLL   = 6'b000000;
   localparam logic [5:0] OP_SRL   = 6'b000010;
   localparam logic [5:0] OP_SRA   = 6'b000011;
   localparam logic [5:0] OP_SLLV  = 6'b000100;
   localparam logic [5:0] OP_SRLV  = 6'b000110;
   localparam logic [5:0] OP_SRAV  = 6'b000111;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_MFHI  = 6'b010000;
   localparam logic [5:0] OP_MTHI  = 6'b010001;
   localparam logic [5:0] OP_MFLO  = 6'b010010;
   localparam logic [5:0] OP_MTLO  = 6'b010011;
   localparam logic [5:0] OP_MULT  = 6'b011000;
   localparam logic [5:0] OP_MULTU = 6'b011001;
   localparam logic [5:0] OP_DIV   = 6'b011010;
   localparam logic [5:0] OP_DIVU  = 6'b011011;
   localparam logic [5:0] OP_ADD   = 6'b100000;
   localparam logic [5:0] OP_ADDU  = 6'b100001;
   localparam logic [5:0] OP_SUB   = 6'b100010;
   localparam logic [5:0] OP_SUBU  = 6'b100011;
   localparam logic [5:0] OP_AND   = 6'b100100;
   localparam logic [5:0] OP_OR    = 6'b100101;
   localparam logic [5:0] OP_XOR   = 6'b100110;
   localparam logic [5:0] OP_NOR   = 6'b100111;
   localparam logic [5:0] OP_SLT   = 6'b101010;
   localparam logic [5:0] OP_SLTU  = 6'b101011;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      FIX,
      ALU_OUT
   } state_t;

   // MULT/MULTU/DIV/DIVU share the 0110xx group
   function automatic logic is_md(input logic [5:0] op);
      return op[5:2] == 4'b0110;
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// iterative shift-add multiplier / restoring divider
// works on magnitudes, sign fixup applied on the result
module muldiv_iter
   import alu_md_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_div,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] hi_res,
   output logic [WIDTH-1:0] lo_res,
   output logic             dbz
);

   logic               run;
   logic [SHW-1:0]     cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   aorig;
   logic               div_q;
   logic               neg_q;
   logic               neg_r;

   logic               sa;
   logic               sb;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH+1:0]   div_dif;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   assign sa    = is_signed & a[WIDTH-1];
   assign sb    = is_signed & b[WIDTH-1];
   assign mag_a = sa ? -a : a;
   assign mag_b = sb ? -b : b;

   // multiplier: upper half accumulates, multiplier bits shift out low
   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, opnd} : '0);

   // divider: partial remainder with next dividend bit shifted in
   assign rem_sh  = acc[2*WIDTH-1:WIDTH-1];
   assign div_dif = {1'b0, rem_sh} - {2'b00, opnd};

   assign done = run && (cnt == '0);

   // load operands on start, then one iteration per cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         run   <= 1'b0;
         cnt   <= '0;
         acc   <= '0;
         opnd  <= '0;
         aorig <= '0;
         div_q <= 1'b0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dbz   <= 1'b0;
      end else if (start) begin
         run   <= 1'b1;
         cnt   <= SHW'(WIDTH - 1);
         acc   <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
         opnd  <= is_div ? mag_b : mag_a;
         aorig <= a;
         div_q <= is_div;
         neg_q <= sa ^ sb;
         neg_r <= sa;
         dbz   <= is_div && (b == '0);
      end else if (run) begin
         if (div_q) begin
            if (div_dif[WIDTH+1])
               acc <= {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
               acc <= {div_dif[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
         end
         if (cnt == '0)
            run <= 1'b0;
         else
            cnt <= cnt - 1'b1;
      end
   end

   // sign correction and divide-by-zero override
   always_comb begin
      prod   = neg_q ? -acc : acc;
      quo    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      hi_res = prod[2*WIDTH-1:WIDTH];
      lo_res = prod[WIDTH-1:0];
      if (div_q) begin
         hi_res = rem;
         lo_res = quo;
         if (dbz) begin
            hi_res = aorig;
            lo_res = '1;
         end
      end
   end

endmodule

// File: rtl/alu_md_seq.sv
// handshaked EX-stage ALU with registered result
// and iterative MULT/DIV feeding architectural HI/LO
module alu_md_seq
   import alu_md_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [5:0]       aluc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] r,
   output logic             zero,
   output logic             carry,
   output logic             negative,
   output logic             overflow,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_t           state;
   logic             take;
   logic             md_op;
   logic             md_done;
   logic             md_dbz;
   logic [WIDTH-1:0] hi_res;
   logic [WIDTH-1:0] lo_res;

   logic [WIDTH:0]   add_s;
   logic [WIDTH-1:0] sub_d;
   logic [SHW-1:0]   sh;
   logic [WIDTH-1:0] alu_r;
   logic             alu_c;
   logic             alu_v;

   assign in_ready = (state == IDLE)
                  || (state == ALU_OUT && out_ready);
   assign take     = in_valid && in_ready;
   assign md_op    = is_md(aluc);

   muldiv_iter #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_md (
      .clk       (clk),
      .rst       (rst),
      .start     (take && md_op),
      .is_div    (aluc[1]),
      .is_signed (~aluc[0]),
      .a         (a),
      .b         (b),
      .done      (md_done),
      .hi_res    (hi_res),
      .lo_res    (lo_res),
      .dbz       (md_dbz)
   );

   assign add_s = {1'b0, a} + {1'b0, b};
   assign sub_d = a - b;
   assign sh    = a[SHW-1:0];

   // single-cycle result and carry/overflow for the current opcode
   always_comb begin
      alu_r = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      unique case (aluc)
         OP_ADD: begin
            alu_r = add_s[WIDTH-1:0];
            alu_c = add_s[WIDTH];
            alu_v = (a[WIDTH-1] == b[WIDTH-1])
                 && (add_s[WIDTH-1] != a[WIDTH-1]);
         end
         OP_ADDU: begin
            alu_r = add_s[WIDTH-1:0];
            alu_c = add_s[WIDTH];
         end
         OP_SUB: begin
            alu_r = sub_d;
            alu_c = a < b;
            alu_v = (a[WIDTH-1] != b[WIDTH-1])
                 && (sub_d[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUBU: begin
            alu_r = sub_d;
            alu_c = a < b;
         end
         OP_AND:  alu_r = a & b;
         OP_OR:   alu_r = a | b;
         OP_XOR:  alu_r = a ^ b;
         OP_NOR:  alu_r = ~(a | b);
         OP_SLT:
            alu_r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU:
            alu_r = {{(WIDTH-1){1'b0}}, a < b};
         OP_SLL, OP_SLLV:  alu_r = b << sh;
         OP_SRL, OP_SRLV:  alu_r = b >> sh;
         OP_SRA, OP_SRAV:  alu_r = $signed(b) >>> sh;
         OP_LUI:
            alu_r = {a[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         OP_MFHI: alu_r = hi;
         OP_MFLO: alu_r = lo;
         OP_MTHI, OP_MTLO: alu_r = a;
         default: alu_r = '0;
      endcase
   end

   // handshake FSM, result register and HI/LO
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         r         <= '0;
         zero      <= 1'b1;
         carry     <= 1'b0;
         negative  <= 1'b0;
         overflow  <= 1'b0;
         hi        <= '0;
         lo        <= '0;
      end else begin
         if (take && aluc == OP_MTHI)
            hi <= a;
         if (take && aluc == OP_MTLO)
            lo <= a;
         unique case (state)
            IDLE, ALU_OUT: begin
               if (take) begin
                  if (md_op) begin
                     state     <= ITER;
                     out_valid <= 1'b0;
                  end else begin
                     state     <= ALU_OUT;
                     out_valid <= 1'b1;
                     r         <= alu_r;
                     zero      <= (alu_r == '0);
                     carry     <= alu_c;
                     negative  <= alu_r[WIDTH-1];
                     overflow  <= alu_v;
                  end
               end else if (state == ALU_OUT && out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            ITER: begin
               if (md_done)
                  state <= FIX;
            end
            FIX: begin
               state     <= ALU_OUT;
               out_valid <= 1'b1;
               r         <= lo_res;
               hi        <= hi_res;
               lo        <= lo_res;
               zero      <= (lo_res == '0);
               carry     <= 1'b0;
               negative  <= lo_res[WIDTH-1];
               overflow  <= md_dbz;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_md_seq.sv
// directed self-checking bench for alu_md_seq
// runs the same suite on a 32-bit and a 16-bit instance
module tb_alu_md_seq;
   import alu_md_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [5:0]  aluc = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   int          cs = 0;

   always #5 clk = ~clk;

   logic        iv32, ir32, ov32, z32, c32, n32, v32;
   logic [31:0] r32, hi32, lo32;
   logic        iv16, ir16, ov16, z16, c16, n16, v16;
   logic [15:0] r16, hi16, lo16;

   assign iv32 = in_valid && (cs == 0);
   assign iv16 = in_valid && (cs == 1);

   alu_md_seq #(.WIDTH(32)) dut32 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv32),
      .in_ready  (ir32),
      .a         (a),
      .b         (b),
      .aluc      (aluc),
      .out_valid (ov32),
      .out_ready (out_ready),
      .r         (r32),
      .zero      (z32),
      .carry     (c32),
      .negative  (n32),
      .overflow  (v32),
      .hi        (hi32),
      .lo        (lo32)
   );

   alu_md_seq #(.WIDTH(16)) dut16 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv16),
      .in_ready  (ir16),
      .a         (a[15:0]),
      .b         (b[15:0]),
      .aluc      (aluc),
      .out_valid (ov16),
      .out_ready (out_ready),
      .r         (r16),
      .zero      (z16),
      .carry     (c16),
      .negative  (n16),
      .overflow  (v16),
      .hi        (hi16),
      .lo        (lo16)
   );

   logic        v_ir, v_ov, v_z, v_c, v_n, v_v;
   logic [31:0] v_r, v_hi, v_lo;

   always_comb begin
      if (cs == 1) begin
         v_ir = ir16; v_ov = ov16;
         v_z = z16; v_c = c16; v_n = n16; v_v = v16;
         v_r  = {16'h0, r16};
         v_hi = {16'h0, hi16};
         v_lo = {16'h0, lo16};
      end else begin
         v_ir = ir32; v_ov = ov32;
         v_z = z32; v_c = c32; v_n = n32; v_v = v32;
         v_r = r32; v_hi = hi32; v_lo = lo32;
      end
   end

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s (w%0d): got %h want %h",
                  tag, (cs == 1) ? 16 : 32, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [5:0] op,
                       input logic [31:0] x,
                       input logic [31:0] y);
      in_valid = 1'b1;
      aluc     = op;
      a        = x;
      b        = y;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_ov(output int n);
      n = 0;
      while (n < 100) begin
         tick();
         n++;
         if (v_ov) break;
      end
   endtask

   task automatic suite(input int s);
      int          w;
      int          n;
      logic [31:0] m;
      logic [31:0] top;
      cs  = s;
      w   = (s == 1) ? 16 : 32;
      m   = (s == 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      top = (m >> 1) + 32'd1;
      out_ready = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      chk("rst_in_ready", v_ir, 1);
      chk("rst_out_valid", v_ov, 0);
      chk("rst_r", v_r, 0);
      chk("rst_zero", v_z, 1);
      chk("rst_hi", v_hi, 0);
      chk("rst_lo", v_lo, 0);
      rst = 1'b0;

      send(OP_ADD, m >> 1, 32'd1);
      chk("add_valid", v_ov, 1);
      chk("add_r", v_r, top);
      chk("add_ovf", v_v, 1);
      chk("add_neg", v_n, 1);
      chk("add_carry", v_c, 0);

      send(OP_SUBU, 32'd0, 32'd1);
      chk("subu_r", v_r, m);
      chk("subu_carry", v_c, 1);
      chk("subu_ovf", v_v, 0);

      send(OP_SRAV, 32'h24, top);
      chk("srav_r", v_r, m ^ (m >> 5));

      send(OP_LUI, 32'h1234, 32'd0);
      chk("lui_r", v_r, (s == 1) ? 32'h3400 : 32'h1234_0000);

      send(OP_SLT, m, 32'd1);
      chk("slt_r", v_r, 1);
      chk("slt_zero", v_z, 0);

      send(6'b111111, 32'h55, 32'h66);
      chk("undef_r", v_r, 0);
      chk("undef_zero", v_z, 1);

      send(OP_MULT, 32'hFFFF_FFFD & m, 32'd5);
      chk("mult_busy", v_ir, 0);
      wait_ov(n);
      chk("mult_lat", n, w + 1);
      chk("mult_hi", v_hi, m);
      chk("mult_lo", v_lo, 32'hFFFF_FFF1 & m);
      chk("mult_r", v_r, 32'hFFFF_FFF1 & m);

      send(OP_DIV, 32'hFFFF_FFF9 & m, 32'd2);
      wait_ov(n);
      chk("div_lat", n, w + 1);
      chk("div_lo", v_lo, 32'hFFFF_FFFD & m);
      chk("div_hi", v_hi, m);
      send(OP_MFHI, 32'd0, 32'd0);
      chk("mfhi_r", v_r, m);

      send(OP_DIVU, 32'd9, 32'd0);
      out_ready = 1'b0;
      wait_ov(n);
      chk("dbz_lo", v_lo, m);
      chk("dbz_hi", v_hi, 9);
      chk("dbz_ovf", v_v, 1);
      in_valid = 1'b1;
      aluc     = OP_MTHI;
      a        = 32'h77;
      b        = 32'h1;
      repeat (5) tick();
      chk("bp_in_ready", v_ir, 0);
      chk("bp_valid", v_ov, 1);
      chk("bp_r", v_r, m);
      chk("bp_hi", v_hi, 9);
      chk("bp_lo", v_lo, m);
      chk("bp_ovf", v_v, 1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();

      send(OP_DIVU, 32'd100, 32'd7);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      chk("mid_in_ready", v_ir, 1);
      chk("mid_out_valid", v_ov, 0);
      chk("mid_r", v_r, 0);
      chk("mid_zero", v_z, 1);
      chk("mid_ovf", v_v, 0);
      chk("mid_hi", v_hi, 0);
      chk("mid_lo", v_lo, 0);
      rst = 1'b0;
      tick();
   endtask

   initial begin
      suite(0);
      suite(1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

endmodule

// File: doc/alu_md_seq.md
# alu_md_seq

Parametrised, handshaked successor to the combinational MIPS ALU. Width is configurable. The output is registered, and the block adds an iterative multiply/divide unit with architectural HI/LO registers. It sits in the EX stage and accepts one operation at a time over a valid/ready interface. The core stalls on `in_ready` while a multi-cycle MULT/DIV is in progress.

## Interface
- `WIDTH`, 32: datapath width; must be even and ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width (derived; do not override).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation present on `a`, `b`, `aluc`.
- `in_ready`  out  1  block can accept; a transfer occurs when `in_valid && in_ready`.
- `a`, `b`  in  WIDTH  operands.
- `aluc`  in  6  opcode.
- `out_valid`  out  1  result held on `r` and the flags.
- `out_ready`  in  1  consumer accepts; result retires when `out_valid && out_ready`.
- `r`  out  WIDTH  result.
- `zero`, `carry`, `negative`, `overflow`  out  1 each  status flags for `r`.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.

## Operation
- **Single-cycle ALU ops (existing encodings):**
  - ADD 100000, ADDU 100001, SUB 100010, SUBU 100011.
  - AND 100100, OR 100101, XOR 100110, NOR 100111.
  - SLT 101010, SLTU 101011.
  - SLL 000000, SRL 000010, SRA 000011, SLLV 000100, SRLV 000110, SRAV 000111.
  - LUI 001111.
- **New ops:**
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
- **Shifts:** all six use `a[SHW-1:0]` as the amount; upper bits are ignored. Shifted value is `b`; SRA/SRAV are arithmetic.
- **LUI:** `r = {a[WIDTH/2-1:0], WIDTH/2 zeros}`.
- **SLT/SLTU:** `r` = 0 or 1 zero-extended.
- **Flags:**
  - `zero = (r==0)` and `negative = r[WIDTH-1]` for every op.
  - `carry`: carry-out for ADD/ADDU; borrow (`a<b` unsigned) for SUB/SUBU; 0 otherwise.
  - `overflow`: signed overflow for ADD/SUB only; also 1 on DIV/DIVU with `b==0`; 0 otherwise.
  - ADD/SUB still write `r` on overflow; there is no trap.
- **MULT/MULTU:**
  - Shift-add over WIDTH iterations on operand magnitudes; MULT negates the 2·WIDTH product when operand signs differ.
  - Result: `{hi,lo}` = product; `r = lo`.
- **DIV/DIVU:**
  - Restoring division over WIDTH iterations.
  - DIV truncates toward zero; remainder takes the sign of the dividend.
  - Result: `lo` = quotient, `hi` = remainder, `r = lo`.
  - Divide by zero: `lo` = all ones, `hi = a`, `overflow = 1`.
  - DIV of most-negative by −1: `lo` = most-negative, `hi = 0`, `overflow = 0`.
- **MTHI/MTLO:** write `a` to `hi`/`lo`; `r = a`.
- **MFHI/MFLO:** `r = hi`/`lo`.
- **Undefined `aluc`:** `r = 0`, all flags 0 except `zero = 1`; the result is still returned (never Z).
- **FSM states:**
  - IDLE → ALU_OUT on an accepted single-cycle op.
  - IDLE → ITER on an accepted MULT/DIV; ITER runs a counter from WIDTH−1 down to 0.
  - ITER → FIX (sign correction, 1 cycle) → ALU_OUT.
  - ALU_OUT → IDLE when `out_ready`. ALU_OUT → ALU_OUT when `out_ready` and a new single-cycle op is accepted in the same cycle.

## Timing
- **Reset values:** `in_ready = 1`, `out_valid = 0`, `r = 0`, `zero = 1`, other flags 0, `hi = lo = 0`, FSM IDLE, counter 0.
- **`in_ready`:** `(state==IDLE) || (state==ALU_OUT && out_ready)`; it is combinational from `out_ready`.
- **Single-cycle op:** accepted at edge N; `out_valid` is 1 after edge N. Throughput is one op per cycle under continuous `out_ready`.
- **MULT/DIV:** accepted at edge N; `out_valid` and the new `hi`/`lo` appear after edge N+WIDTH+1 (WIDTH iterations plus FIX). `in_ready = 0` throughout.
- **MTHI/MTLO:** `hi`/`lo` update at the accept edge.
- **Back-to-back dependency:** an MFHI accepted in the cycle `out_valid` of a DIV is seen reads the updated HI.
- **Backpressure:** while `out_valid && !out_ready`, `r`, the flags, `hi` and `lo` hold stable and no new op is accepted.
- **Reset mid-ITER or with `out_valid` high:** the result is discarded, `hi`/`lo` clear, and the block returns to the reset values at the next edge.
- `in_valid` while `in_ready = 0` is ignored; the operands are not sampled.

## Structure
- Package `alu_md_pkg`: the 6-bit opcode localparams (all above) and the FSM state enum (IDLE, ITER, FIX, ALU_OUT).
- Sub-module `muldiv_iter`:
  - Contains the counter, the 2·WIDTH accumulator/remainder and the sign fixup.
  - Interface: `start`, `is_div`, `is_signed`, `a`, `b` in; `done`, `hi_res`, `lo_res`, `dbz` out.
- Top level owns the combinational ALU, the output register, HI/LO and the handshake.

## Test plan
- **ADD overflow:** ADD `a=0x7FFFFFFF`, `b=1` → next cycle `r=0x80000000`, `overflow=1`, `negative=1`, `carry=0`.
- **SUBU borrow:** SUBU `0 − 1` → `r=0xFFFFFFFF`, `carry=1`, `overflow=0`.
- **SRAV masking:** SRAV `a=0x24`, `b=0x80000000` → `r=0xF8000000` (amount 4).
- **Signed multiply:** MULT `a=−3`, `b=5` → `out_valid` 33 cycles after accept; `hi=0xFFFFFFFF`, `lo=0xFFFFFFF1`.
- **Divide then MFHI:**
  - DIV `a=−7`, `b=2` → `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`.
  - MFHI accepted in the cycle `out_valid` of the DIV is seen → `r=0xFFFFFFFF`.
- **Divide by zero with backpressure, then reset:**
  - DIVU `a=9`, `b=0` with `out_ready=0` for 5 cycles → `lo=0xFFFFFFFF`, `hi=9`, `overflow=1`, all held stable.
  - Then `rst` asserted mid-DIV → all outputs at reset values.
  - Repeat the suite with `WIDTH=16`.
